// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the raster video source and the filter-side index
// logic:
//   - counter widths (h 11 bits, v 10 bits)
//   - default 1600x900 timing (active, front porch, sync, back porch per axis)
//   - default impulse coordinates
//   - test-pattern encoding
//   - generator FSM state encoding and the region-decode bundle
//   - a geometry check used at elaboration
// -----------------------------------------------------------------------------
package video_timing_pkg;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  localparam int DEF_H_ACTIVE = 1600;
  localparam int DEF_H_FP     = 48;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 80;
  localparam int DEF_V_ACTIVE = 900;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 18;
  localparam int DEF_IMP_X    = 800;
  localparam int DEF_IMP_Y    = 450;

  localparam logic [1:0] PAT_HRAMP   = 2'd0;
  localparam logic [1:0] PAT_VRAMP   = 2'd1;
  localparam logic [1:0] PAT_CHECK   = 2'd2;
  localparam logic [1:0] PAT_IMPULSE = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Combinational decode of the current counter position.
  typedef struct packed {
    logic h_act;
    logic v_act;
    logic hs;
    logic vs;
    logic eof;   // last back-porch cycle of the frame
  } region_t;

  // A total of 2^W still fits: the counter only ever holds 0..total-1.
  function automatic bit totals_fit(input int h_total, input int v_total);
    return (h_total <= (1 << H_CNT_W)) && (v_total <= (1 << V_CNT_W)) &&
           (h_total > 0) && (v_total > 0);
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// -----------------------------------------------------------------------------
// video_timing_counter
// Horizontal/vertical raster counters with clear and enable, plus region
// decode. Region order on each axis is active, front porch, sync, back porch.
//
// Ports:
//   clk     in   pixel clock
//   rst     in   synchronous active-high reset (counters to 0)
//   clr     in   synchronous clear (counters to 0)
//   en      in   advance one pixel
//   h_cnt   out  horizontal position 0..H_TOTAL-1
//   v_cnt   out  line number 0..V_TOTAL-1
//   region  out  h_act, v_act, hs, vs, eof decoded from the current counts
// -----------------------------------------------------------------------------
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output region_t            region
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

  // Geometry that cannot be represented by the fixed counter widths is
  // rejected while elaborating rather than silently wrapping early.
  if (!totals_fit(H_TOTAL, V_TOTAL)) begin : g_bad_geometry
    $error("video_timing_counter: H_TOTAL=%0d or V_TOTAL=%0d exceeds counter width",
           H_TOTAL, V_TOTAL);
  end

  logic h_last;
  logic v_last;

  // Comparisons are done in int so parameters of any legal value compare
  // without truncation.
  assign h_last = (int'(h_cnt) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt) == V_TOTAL - 1);

  // Stage p0: raster position
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    region       = '0;
    region.h_act = (int'(h_cnt) < H_ACTIVE);
    region.v_act = (int'(v_cnt) < V_ACTIVE);
    region.hs    = (int'(h_cnt) >= H_SYNC_BEG) && (int'(h_cnt) < H_SYNC_END);
    region.vs    = (int'(v_cnt) >= V_SYNC_BEG) && (int'(v_cnt) < V_SYNC_END);
    region.eof   = h_last && v_last;
  end

endmodule

// File: rtl/video_stream_gen.sv
// -----------------------------------------------------------------------------
// video_stream_gen
// Raster test-pattern source feeding the 2D FIR line-buffer/window stage.
// Produces 8-bit luma with data valid, hsync and vsync, one registered output
// stage behind the raster counters.
//
// Ports:
//   clk           in   pixel clock
//   rst           in   synchronous active-high reset, priority over en_i
//   en_i          in   run request; only acted on at frame boundaries
//   pattern_i     in   0 h-ramp, 1 v-ramp, 2 checker, 3 impulse
//   y_o           out  luma, 0 outside the active region
//   dv_o          out  pixel valid
//   hs_o          out  horizontal sync, active high, every line
//   vs_o          out  vertical sync, active high level for V_SYNC lines
//   frame_done_o  out  pulse on the last active pixel of a frame
//   busy_o        out  registered copy of "FSM in RUN"
// -----------------------------------------------------------------------------
module video_stream_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int IMP_X    = DEF_IMP_X,
  parameter int IMP_Y    = DEF_IMP_Y
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] pattern_i,
  output logic [7:0] y_o,
  output logic       dv_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       frame_done_o,
  output logic       busy_o
);

  state_t             state;
  logic [1:0]         pat_q;

  logic               run_p0;
  logic [H_CNT_W-1:0] h_cnt_p0;
  logic [V_CNT_W-1:0] v_cnt_p0;
  region_t            region_p0;
  logic               dv_p0;
  logic               fd_p0;
  logic [7:0]         pix_p0;

  function automatic logic [7:0] pattern_pixel(input logic [1:0]         pat,
                                               input logic [H_CNT_W-1:0] x,
                                               input logic [V_CNT_W-1:0] l);
    logic [7:0] px;
    px = 8'd0;
    case (pat)
      PAT_HRAMP:   px = x[7:0];
      PAT_VRAMP:   px = l[7:0];
      PAT_CHECK:   px = (x[3] ^ l[3]) ? 8'hFF : 8'h00;
      PAT_IMPULSE: px = ((int'(x) == IMP_X) && (int'(l) == IMP_Y)) ? 8'hFF : 8'h00;
      default:     px = 8'h00;
    endcase
    return px;
  endfunction

  assign run_p0 = (state == ST_RUN);

  // Counters are held at zero whenever the FSM is idle, so the first RUN
  // cycle always starts at x=0, l=0.
  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .clr    (!run_p0),
    .en     (run_p0),
    .h_cnt  (h_cnt_p0),
    .v_cnt  (v_cnt_p0),
    .region (region_p0)
  );

  assign dv_p0  = run_p0 & region_p0.h_act & region_p0.v_act;
  assign fd_p0  = dv_p0 & (int'(h_cnt_p0) == H_ACTIVE - 1) &
                  (int'(v_cnt_p0) == V_ACTIVE - 1);
  assign pix_p0 = dv_p0 ? pattern_pixel(pat_q, h_cnt_p0, v_cnt_p0) : 8'd0;

  // Stage p1: FSM and registered outputs
  // The pattern select is only sampled when a frame is about to start, so a
  // frame is never a mix of two patterns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pat_q        <= PAT_HRAMP;
      y_o          <= 8'd0;
      dv_o         <= 1'b0;
      hs_o         <= 1'b0;
      vs_o         <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_i) begin
            state <= ST_RUN;
            pat_q <= pattern_i;
          end
        end
        ST_RUN: begin
          if (region_p0.eof) begin
            if (en_i) begin
              pat_q <= pattern_i;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      y_o          <= pix_p0;
      dv_o         <= dv_p0;
      hs_o         <= run_p0 & region_p0.hs;
      vs_o         <= run_p0 & region_p0.vs;
      frame_done_o <= fd_p0;
      busy_o       <= run_p0;
    end
  end

endmodule

// File: tb/tb_video_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_video_stream_gen
// Directed bench for video_stream_gen. A reduced raster (300x10 active,
// 320x17 total) keeps whole frames short while still crossing the 256-pixel
// ramp wrap and the checker's bit-3 boundaries on both axes.
// -----------------------------------------------------------------------------
module tb_video_stream_gen;

  localparam int HA    = 300;
  localparam int HFP   = 6;
  localparam int HSW   = 4;
  localparam int HBP   = 10;
  localparam int HT    = HA + HFP + HSW + HBP;   // 320
  localparam int VA    = 10;
  localparam int VFP   = 2;
  localparam int VSW   = 3;
  localparam int VBP   = 2;
  localparam int VT    = VA + VFP + VSW + VBP;   // 17
  localparam int FRAME = HT * VT;                // 5440
  localparam int IX    = 150;
  localparam int IY    = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_i;
  logic [1:0] pattern_i;
  logic [7:0] y_o;
  logic       dv_o;
  logic       hs_o;
  logic       vs_o;
  logic       frame_done_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_stream_gen #(
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HSW),
    .H_BP     (HBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP),
    .IMP_X    (IX),
    .IMP_Y    (IY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .pattern_i    (pattern_i),
    .y_o          (y_o),
    .dv_o         (dv_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then request RUN. Returns on the sample right after the edge that
  // enters RUN; outputs there still reflect IDLE.
  task automatic start_run(input logic [1:0] pat);
    rst       = 1'b1;
    en_i      = 1'b0;
    pattern_i = pat;
    step();
    step();
    rst  = 1'b0;
    en_i = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    en_i      = 1'b1;
    pattern_i = 2'd0;
    step();
    step();
    step();
    total++; if (dv_o !== 1'b0) begin bad++; $display("FAIL reset_dv: got %0d want 0", dv_o); end
    total++; if (y_o !== 8'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", y_o); end
    total++; if (hs_o !== 1'b0) begin bad++; $display("FAIL reset_hs: got %0d want 0", hs_o); end
    total++; if (vs_o !== 1'b0) begin bad++; $display("FAIL reset_vs: got %0d want 0", vs_o); end
    total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL reset_fd: got %0d want 0", frame_done_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0d want 0", busy_o); end
  endtask

  task automatic test_hramp_line();
    int errs;
    int first_bad;
    int g;
    int w;
    int blank_errs;
    start_run(2'd0);
    total++; if (dv_o !== 1'b0) begin bad++; $display("FAIL hramp_dv_latency: got %0d want 0", dv_o); end
    step();
    total++; if (dv_o !== 1'b1) begin bad++; $display("FAIL hramp_first_dv: got %0d want 1", dv_o); end
    total++; if (y_o !== 8'd0) begin bad++; $display("FAIL hramp_first_y: got %0d want 0", y_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL hramp_busy: got %0d want 1", busy_o); end
    errs = 0;
    first_bad = -1;
    for (int i = 0; i < HA; i++) begin
      if (dv_o !== 1'b1 || y_o !== 8'(i % 256)) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      step();
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL hramp_pixels: got %0d bad pixels (first at x=%0d) want 0", errs, first_bad); end
    g = 0;
    blank_errs = 0;
    while (hs_o !== 1'b1 && g < HT) begin
      if (dv_o !== 1'b0 || y_o !== 8'd0) blank_errs++;
      g++;
      step();
    end
    total++; if (g !== HFP) begin bad++; $display("FAIL hramp_hs_gap: got %0d want %0d", g, HFP); end
    total++; if (blank_errs !== 0) begin bad++; $display("FAIL hramp_blank: got %0d nonzero want 0", blank_errs); end
    w = 0;
    while (hs_o === 1'b1 && w < HT) begin
      w++;
      step();
    end
    total++; if (w !== HSW) begin bad++; $display("FAIL hramp_hs_width: got %0d want %0d", w, HSW); end
  endtask

  task automatic test_full_frame();
    int ndv, run, nlines, badrun, nvs, nhs, nfd, fd_idx, fd_bad;
    logic prev_hs;
    start_run(2'd0);
    step();
    ndv = 0; run = 0; nlines = 0; badrun = 0; nvs = 0; nhs = 0;
    nfd = 0; fd_idx = -1; fd_bad = 0; prev_hs = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      if (dv_o === 1'b1) begin
        ndv++;
        run++;
      end else if (run > 0) begin
        if (run != HA) badrun++;
        nlines++;
        run = 0;
      end
      if (vs_o === 1'b1) nvs++;
      if (hs_o === 1'b1 && prev_hs !== 1'b1) nhs++;
      prev_hs = hs_o;
      if (frame_done_o === 1'b1) begin
        nfd++;
        fd_idx = ndv - 1;
        if (dv_o !== 1'b1) fd_bad++;
      end
      step();
    end
    total++; if (ndv !== VA * HA) begin bad++; $display("FAIL frame_dv_count: got %0d want %0d", ndv, VA * HA); end
    total++; if (nlines !== VA) begin bad++; $display("FAIL frame_lines: got %0d want %0d", nlines, VA); end
    total++; if (badrun !== 0) begin bad++; $display("FAIL frame_line_len: got %0d bad lines want 0", badrun); end
    total++; if (nvs !== VSW * HT) begin bad++; $display("FAIL frame_vs_cycles: got %0d want %0d", nvs, VSW * HT); end
    total++; if (nhs !== VT) begin bad++; $display("FAIL frame_hs_pulses: got %0d want %0d", nhs, VT); end
    total++; if (nfd !== 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", nfd); end
    total++; if (fd_idx !== VA * HA - 1) begin bad++; $display("FAIL frame_done_pos: got %0d want %0d", fd_idx, VA * HA - 1); end
    total++; if (fd_bad !== 0) begin bad++; $display("FAIL frame_done_dv: got %0d want 0", fd_bad); end
    // en_i still high: the next frame follows with no gap
    total++; if (dv_o !== 1'b1) begin bad++; $display("FAIL next_frame_dv: got %0d want 1", dv_o); end
    total++; if (y_o !== 8'd0) begin bad++; $display("FAIL next_frame_y: got %0d want 0", y_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL next_frame_busy: got %0d want 1", busy_o); end
  endtask

  task automatic test_impulse();
    int ndv, n255, idx, nother;
    start_run(2'd3);
    step();
    ndv = 0; n255 = 0; idx = -1; nother = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (dv_o === 1'b1) begin
        if (y_o === 8'd255) begin
          n255++;
          idx = ndv;
        end else if (y_o !== 8'd0) begin
          nother++;
        end
        ndv++;
      end else if (y_o !== 8'd0) begin
        nother++;
      end
      step();
    end
    total++; if (n255 !== 1) begin bad++; $display("FAIL impulse_count: got %0d want 1", n255); end
    total++; if (idx !== IY * HA + IX) begin bad++; $display("FAIL impulse_pos: got %0d want %0d", idx, IY * HA + IX); end
    total++; if (nother !== 0) begin bad++; $display("FAIL impulse_other: got %0d nonzero want 0", nother); end
  endtask

  task automatic test_pattern_switch();
    int ndv, line, px, expv, errs1, errs2;
    int y_l0p8, y_l0p7, y_l8p0, y_l7p123;
    start_run(2'd2);
    step();
    ndv = 0; errs1 = 0; y_l0p8 = -1; y_l0p7 = -1; y_l8p0 = -1;
    for (int k = 0; k < FRAME; k++) begin
      if (k == 2 * HT) pattern_i = 2'd1;
      if (dv_o === 1'b1) begin
        line = ndv / HA;
        px   = ndv % HA;
        expv = (((px >> 3) ^ (line >> 3)) & 1) != 0 ? 255 : 0;
        if (int'(y_o) != expv) errs1++;
        if (line == 0 && px == 7) y_l0p7 = int'(y_o);
        if (line == 0 && px == 8) y_l0p8 = int'(y_o);
        if (line == 8 && px == 0) y_l8p0 = int'(y_o);
        ndv++;
      end
      step();
    end
    total++; if (y_l0p7 !== 0) begin bad++; $display("FAIL checker_l0_p7: got %0d want 0", y_l0p7); end
    total++; if (y_l0p8 !== 255) begin bad++; $display("FAIL checker_l0_p8: got %0d want 255", y_l0p8); end
    total++; if (y_l8p0 !== 255) begin bad++; $display("FAIL checker_l8_p0: got %0d want 255", y_l8p0); end
    total++; if (errs1 !== 0) begin bad++; $display("FAIL checker_frame: got %0d bad pixels want 0", errs1); end
    ndv = 0; errs2 = 0; y_l7p123 = -1;
    for (int k = 0; k < FRAME; k++) begin
      if (dv_o === 1'b1) begin
        line = ndv / HA;
        if (int'(y_o) != (line % 256)) errs2++;
        if (line == 7 && (ndv % HA) == 123) y_l7p123 = int'(y_o);
        ndv++;
      end
      step();
    end
    total++; if (y_l7p123 !== 7) begin bad++; $display("FAIL vramp_l7: got %0d want 7", y_l7p123); end
    total++; if (errs2 !== 0) begin bad++; $display("FAIL vramp_frame: got %0d bad pixels want 0", errs2); end
    total++; if (ndv !== VA * HA) begin bad++; $display("FAIL vramp_dv_count: got %0d want %0d", ndv, VA * HA); end
  endtask

  task automatic test_en_drop();
    int ndv, idle_errs;
    logic busy_last;
    start_run(2'd0);
    step();
    ndv = 0; busy_last = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == 500) en_i = 1'b0;
      if (dv_o === 1'b1) ndv++;
      if (k == FRAME - 1) busy_last = busy_o;
      step();
    end
    total++; if (ndv !== VA * HA) begin bad++; $display("FAIL endrop_dv_count: got %0d want %0d", ndv, VA * HA); end
    total++; if (busy_last !== 1'b1) begin bad++; $display("FAIL endrop_busy_last_bp: got %0d want 1", busy_last); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL endrop_busy_fall: got %0d want 0", busy_o); end
    idle_errs = 0;
    for (int k = 0; k < 20; k++) begin
      if (dv_o !== 1'b0 || y_o !== 8'd0 || hs_o !== 1'b0 || vs_o !== 1'b0 ||
          frame_done_o !== 1'b0 || busy_o !== 1'b0) idle_errs++;
      step();
    end
    total++; if (idle_errs !== 0) begin bad++; $display("FAIL endrop_idle_outputs: got %0d nonzero cycles want 0", idle_errs); end
    en_i = 1'b1;
    step();
    total++; if (dv_o !== 1'b0) begin bad++; $display("FAIL restart_latency: got %0d want 0", dv_o); end
    step();
    total++; if (dv_o !== 1'b1) begin bad++; $display("FAIL restart_dv: got %0d want 1", dv_o); end
    total++; if (y_o !== 8'd0) begin bad++; $display("FAIL restart_y0: got %0d want 0", y_o); end
    total++; if (vs_o !== 1'b0) begin bad++; $display("FAIL restart_vs: got %0d want 0", vs_o); end
    step();
    total++; if (y_o !== 8'd1) begin bad++; $display("FAIL restart_y1: got %0d want 1", y_o); end
  endtask

  task automatic test_reset_mid();
    int ndv, ndv_at_fd;
    bit found;
    start_run(2'd0);
    step();
    // Sample k is taken during RUN cycle k+1; stop on the one showing x=199
    // of line 3 so that rst lands on the cycle at line 3 pixel 200.
    for (int k = 0; k < 3 * HT + 199; k++) step();
    total++; if (y_o !== 8'd199) begin bad++; $display("FAIL midrst_pre_pixel: got %0d want 199", y_o); end
    rst = 1'b1;
    step();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0d want 0", busy_o); end
    rst = 1'b0;
    step();
    total++; if (dv_o !== 1'b0) begin bad++; $display("FAIL midrst_dv: got %0d want 0", dv_o); end
    total++; if (hs_o !== 1'b0) begin bad++; $display("FAIL midrst_hs: got %0d want 0", hs_o); end
    total++; if (vs_o !== 1'b0) begin bad++; $display("FAIL midrst_vs: got %0d want 0", vs_o); end
    total++; if (y_o !== 8'd0) begin bad++; $display("FAIL midrst_y: got %0d want 0", y_o); end
    step();
    total++; if (dv_o !== 1'b1) begin bad++; $display("FAIL midrst_restart_dv: got %0d want 1", dv_o); end
    total++; if (y_o !== 8'd0) begin bad++; $display("FAIL midrst_restart_y: got %0d want 0", y_o); end
    ndv = 0; ndv_at_fd = -1; found = 1'b0;
    for (int k = 0; k < FRAME + 10 && !found; k++) begin
      if (dv_o === 1'b1) ndv++;
      if (frame_done_o === 1'b1) begin
        found = 1'b1;
        ndv_at_fd = ndv;
      end
      step();
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL midrst_fd_timeout: got %0d want 1", found); end
    total++; if (ndv_at_fd !== VA * HA) begin bad++; $display("FAIL midrst_fd_pos: got %0d want %0d", ndv_at_fd, VA * HA); end
  endtask

  initial begin
    rst       = 1'b1;
    en_i      = 1'b0;
    pattern_i = 2'd0;
    test_reset();
    test_hramp_line();
    test_full_frame();
    test_impulse();
    test_pattern_switch();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
